// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter
//   Round-robin arbiter and sequencer that shares one serial adder among NREQ
//   requesters. It captures the winning operand pair, holds the adder's start
//   through RUN, waits for the adder to return to idle, and presents sum,
//   carry-out, owner ID and a timeout flag on a valid/ready response port.
//
// Ports
//   i_clk, i_rst          clock (rising edge); synchronous active-low reset
//   i_req                 per-requester request, held until its o_gnt bit
//   i_a_in, i_b_in        packed operands, requester i at [i*WIDTH +: WIDTH]
//   o_gnt                 one-hot, one-cycle grant pulse
//   o_add_a, o_add_b      registered operands to the adder
//   o_add_start           adder start, high for all of RUN
//   o_add_clr             active-high adder clear (reset and timeout)
//   i_add_done            adder done level
//   i_add_sum, i_add_cout adder result
//   o_rsp_valid           response valid; i_rsp_ready consumer ready
//   o_rsp_sum, o_rsp_cout response data; o_rsp_id owner index
//   o_rsp_err             operation timed out (sum and carry forced to 0)
module serial_add_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned IDW     = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_a_in,
  input  logic [NREQ*WIDTH-1:0] i_b_in,
  output logic [NREQ-1:0]       o_gnt,
  output logic [WIDTH-1:0]      o_add_a,
  output logic [WIDTH-1:0]      o_add_b,
  output logic                  o_add_start,
  output logic                  o_add_clr,
  input  logic                  i_add_done,
  input  logic [WIDTH-1:0]      i_add_sum,
  input  logic                  i_add_cout,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [WIDTH-1:0]      o_rsp_sum,
  output logic                  o_rsp_cout,
  output logic [IDW-1:0]        o_rsp_id,
  output logic                  o_rsp_err
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StResp} state_e;

  state_e            r_state, w_state_d;
  logic [IDW-1:0]    r_ptr, w_ptr_d;
  logic [WDW-1:0]    r_wdog, w_wdog_d;
  logic [IDW-1:0]    r_owner, w_owner_d;
  logic [NREQ-1:0]   r_gnt, w_gnt_d;
  logic [WIDTH-1:0]  r_add_a, w_add_a_d;
  logic [WIDTH-1:0]  r_add_b, w_add_b_d;
  logic              r_add_start, w_add_start_d;
  logic              r_add_clr, w_add_clr_d;
  logic              r_rsp_valid, w_rsp_valid_d;
  logic [WIDTH-1:0]  r_rsp_sum, w_rsp_sum_d;
  logic              r_rsp_cout, w_rsp_cout_d;
  logic [IDW-1:0]    r_rsp_id, w_rsp_id_d;
  logic              r_rsp_err, w_rsp_err_d;

  // Winner search: first set request at or above r_ptr, wrapping at NREQ.
  logic              w_found;
  logic [IDW-1:0]    w_win;
  logic [31:0]       w_idx;
  logic [NREQ-1:0]   w_onehot;
  logic [WIDTH-1:0]  w_sel_a, w_sel_b;
  logic [IDW-1:0]    w_ptr_next;

  always_comb begin
    w_found  = 1'b0;
    w_win    = '0;
    w_idx    = '0;
    w_onehot = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = 32'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!w_found && (w_idx == i) && i_req[i]) begin
          w_found = 1'b1;
          w_win   = IDW'(i);
        end
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_onehot[i] = w_found && (w_win == IDW'(i));
      if (w_onehot[i]) begin
        w_sel_a = i_a_in[i*WIDTH +: WIDTH];
        w_sel_b = i_b_in[i*WIDTH +: WIDTH];
      end
    end
    w_ptr_next = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
  end

  always_comb begin
    w_state_d     = r_state;
    w_ptr_d       = r_ptr;
    w_wdog_d      = r_wdog;
    w_owner_d     = r_owner;
    w_gnt_d       = '0;
    w_add_a_d     = r_add_a;
    w_add_b_d     = r_add_b;
    w_add_start_d = r_add_start;
    w_add_clr_d   = 1'b0;
    w_rsp_valid_d = r_rsp_valid;
    w_rsp_sum_d   = r_rsp_sum;
    w_rsp_cout_d  = r_rsp_cout;
    w_rsp_id_d    = r_rsp_id;
    w_rsp_err_d   = r_rsp_err;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_gnt_d       = w_onehot;
          w_add_a_d     = w_sel_a;
          w_add_b_d     = w_sel_b;
          w_owner_d     = w_win;
          w_ptr_d       = w_ptr_next;
          w_wdog_d      = '0;
          w_add_start_d = 1'b1;
          w_state_d     = StRun;
        end
      end
      StRun: begin
        w_wdog_d = r_wdog + 1'b1;
        // add_done wins over a coinciding timeout.
        if (i_add_done) begin
          w_rsp_sum_d   = i_add_sum;
          w_rsp_cout_d  = i_add_cout;
          w_rsp_err_d   = 1'b0;
          w_rsp_id_d    = r_owner;
          w_add_start_d = 1'b0;
          w_state_d     = StDrain;
        end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
          w_rsp_sum_d   = '0;
          w_rsp_cout_d  = 1'b0;
          w_rsp_err_d   = 1'b1;
          w_rsp_id_d    = r_owner;
          w_add_clr_d   = 1'b1;
          w_add_start_d = 1'b0;
          w_state_d     = StDrain;
        end
      end
      StDrain: begin
        // After a timeout the clear has already idled the adder; do not wait on done.
        if (r_rsp_err || !i_add_done) begin
          w_rsp_valid_d = 1'b1;
          w_state_d     = StResp;
        end
      end
      StResp: begin
        if (i_rsp_ready) begin
          w_rsp_valid_d = 1'b0;
          w_state_d     = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_wdog      <= '0;
      r_owner     <= '0;
      r_gnt       <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_start <= 1'b0;
      r_add_clr   <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_ptr       <= w_ptr_d;
      r_wdog      <= w_wdog_d;
      r_owner     <= w_owner_d;
      r_gnt       <= w_gnt_d;
      r_add_a     <= w_add_a_d;
      r_add_b     <= w_add_b_d;
      r_add_start <= w_add_start_d;
      r_add_clr   <= w_add_clr_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_sum   <= w_rsp_sum_d;
      r_rsp_cout  <= w_rsp_cout_d;
      r_rsp_id    <= w_rsp_id_d;
      r_rsp_err   <= w_rsp_err_d;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_add_a     = r_add_a;
  assign o_add_b     = r_add_b;
  assign o_add_start = r_add_start;
  assign o_add_clr   = r_add_clr;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_sum   = r_rsp_sum;
  assign o_rsp_cout  = r_rsp_cout;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// tb_serial_add_arbiter
//   Scoreboard bench for serial_add_arbiter with a behavioural serial adder.
//   Stimulus pushes hand-computed grants and responses into queues; monitors
//   pop and compare whenever the DUT grants or completes a response.
module tb_serial_add_arbiter;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned IDW     = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in, b_in;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      add_a, add_b, add_sum, rsp_sum;
  logic                  add_start, add_clr, add_done, add_cout;
  logic                  rsp_valid, rsp_ready, rsp_cout, rsp_err;
  logic [IDW-1:0]        rsp_id;
  logic                  hang;

  always #5 clk = ~clk;

  serial_add_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .IDW(IDW)
  ) u_dut (
    .i_clk(clk), .i_rst(rst_n), .i_req(req), .i_a_in(a_in), .i_b_in(b_in),
    .o_gnt(gnt), .o_add_a(add_a), .o_add_b(add_b), .o_add_start(add_start),
    .o_add_clr(add_clr), .i_add_done(add_done), .i_add_sum(add_sum),
    .i_add_cout(add_cout), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_sum(rsp_sum), .o_rsp_cout(rsp_cout), .o_rsp_id(rsp_id), .o_rsp_err(rsp_err)
  );

  // Behavioural serial adder: LOAD, WIDTH ADD cycles, DONE until start drops.
  typedef enum logic [1:0] {MIdle, MLoad, MAdd, MDone} mst_e;
  mst_e       m_st = MIdle;
  logic [5:0] m_cnt = '0;
  logic       m_cout = 1'b0;
  logic [WIDTH-1:0] m_sum = '0;

  always @(posedge clk) begin
    if (add_clr) begin
      m_st  <= MIdle;
      m_cnt <= '0;
    end else begin
      case (m_st)
        MIdle: if (add_start) m_st <= MLoad;
        MLoad: begin
          {m_cout, m_sum} <= {1'b0, add_a} + {1'b0, add_b};
          m_cnt <= '0;
          m_st  <= MAdd;
        end
        MAdd: begin
          m_cnt <= m_cnt + 6'd1;
          if (m_cnt == 6'(WIDTH - 1)) m_st <= MDone;
        end
        MDone: if (!add_start) m_st <= MIdle;
        default: m_st <= MIdle;
      endcase
    end
  end
  assign add_done = (m_st == MDone) && !hang;
  assign add_sum  = m_sum;
  assign add_cout = m_cout;

  typedef struct {
    int unsigned      id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } gnt_t;
  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    int unsigned      id;
    logic             err;
  } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   clr_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_g(input int unsigned id, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
    gnt_t g;
    g.id = id; g.a = a; g.b = b;
    gq.push_back(g);
  endtask

  task automatic push_r(input logic [WIDTH-1:0] sum, input logic cout,
                        input int unsigned id, input logic err);
    rsp_t r;
    r.sum = sum; r.cout = cout; r.id = id; r.err = err;
    rq.push_back(r);
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    a_in[i*WIDTH +: WIDTH] = a;
    b_in[i*WIDTH +: WIDTH] = b;
  endtask

  // Grant monitor
  always @(negedge clk) begin : mon_gnt
    gnt_t g;
    if (gnt !== '0) begin
      if (gq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_grant: got gnt=%b, want none", gnt);
      end else begin
        g = gq.pop_front();
        chk("gnt", 64'(gnt), 64'(1) << g.id);
        chk("add_a", 64'(add_a), 64'(g.a));
        chk("add_b", 64'(add_b), 64'(g.b));
        chk("add_start", 64'(add_start), 64'(1));
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin : mon_rsp
    rsp_t r;
    if (rsp_valid && rsp_ready) begin
      if (rq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: got id=%0d sum=0x%0h, want none", rsp_id, rsp_sum);
      end else begin
        r = rq.pop_front();
        chk("rsp_sum", 64'(rsp_sum), 64'(r.sum));
        chk("rsp_cout", 64'(rsp_cout), 64'(r.cout));
        chk("rsp_id", 64'(rsp_id), 64'(r.id));
        chk("rsp_err", 64'(rsp_err), 64'(r.err));
      end
    end
  end

  always @(negedge clk) if (add_clr) clr_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [NREQ-1:0] g, input int budget);
    g = '0;
    for (int c = 0; c < budget && g == '0; c++) begin
      @(negedge clk);
      g = gnt;
    end
    if (g == '0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL grant_timeout: got no grant, want one within %0d cycles", budget);
    end
  endtask

  task automatic run_ops(input logic [NREQ-1:0] mask, input int n, input bit drop);
    logic [NREQ-1:0] g;
    req = mask;
    for (int k = 0; k < n; k++) begin
      wait_grant(g, 300);
      if (drop) req = req & ~g;
    end
    req = '0;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((rq.size() != 0 || gq.size() != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (rq.size() != 0 || gq.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d rsp / %0d gnt pending, want 0", rq.size(), gq.size());
      rq.delete();
      gq.delete();
    end
    tick();
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'(0));
    chk({tag, "_add_start"}, 64'(add_start), 64'(0));
    chk({tag, "_add_a"}, 64'(add_a), 64'(0));
    chk({tag, "_add_b"}, 64'(add_b), 64'(0));
    chk({tag, "_add_clr"}, 64'(add_clr), 64'(1));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_sum"}, 64'(rsp_sum), 64'(0));
    chk({tag, "_rsp_cout"}, 64'(rsp_cout), 64'(0));
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'(0));
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, want finish before 500us");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] g;
    int c;
    rst_n = 1'b0; req = '0; rsp_ready = 1'b1; hang = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("clr_release", 64'(add_clr), 64'(0));

    // Single request on requester 0
    set_op(0, 32'h0000_0005, 32'h0000_0003);
    push_g(0, 32'h5, 32'h3);
    push_r(32'h8, 1'b0, 0, 1'b0);
    run_ops(4'b0001, 1, 1'b1);
    drain(200);

    // Carry-out on requester 2 (ptr now 1)
    set_op(2, 32'hFFFF_FFFF, 32'h0000_0001);
    push_g(2, 32'hFFFF_FFFF, 32'h1);
    push_r(32'h0, 1'b1, 2, 1'b0);
    run_ops(4'b0100, 1, 1'b1);
    drain(200);

    // Round-robin operand set
    set_op(0, 32'h0000_0001, 32'h0000_0002);
    set_op(1, 32'h0000_0010, 32'h0000_0020);
    set_op(2, 32'h8000_0000, 32'h8000_0000);
    set_op(3, 32'h1234_5678, 32'h1111_1111);
    // Requester 3 alone brings ptr back to 0
    push_g(3, 32'h1234_5678, 32'h1111_1111);
    push_r(32'h2345_6789, 1'b0, 3, 1'b0);
    run_ops(4'b1000, 1, 1'b1);
    drain(200);
    // All four held: order 0,1,2,3,0
    push_g(0, 32'h1, 32'h2);                   push_r(32'h3, 1'b0, 0, 1'b0);
    push_g(1, 32'h10, 32'h20);                 push_r(32'h30, 1'b0, 1, 1'b0);
    push_g(2, 32'h8000_0000, 32'h8000_0000);   push_r(32'h0, 1'b1, 2, 1'b0);
    push_g(3, 32'h1234_5678, 32'h1111_1111);   push_r(32'h2345_6789, 1'b0, 3, 1'b0);
    push_g(0, 32'h1, 32'h2);                   push_r(32'h3, 1'b0, 0, 1'b0);
    run_ops(4'b1111, 5, 1'b0);
    drain(800);
    // ptr = 1, req = 0101: requester 2 first, then 0
    push_g(2, 32'h8000_0000, 32'h8000_0000);   push_r(32'h0, 1'b1, 2, 1'b0);
    push_g(0, 32'h1, 32'h2);                   push_r(32'h3, 1'b0, 0, 1'b0);
    run_ops(4'b0101, 2, 1'b1);
    drain(400);

    // Backpressure (ptr = 1)
    tick();
    rsp_ready = 1'b0;
    push_g(1, 32'h10, 32'h20);                 push_r(32'h30, 1'b0, 1, 1'b0);
    push_g(2, 32'h8000_0000, 32'h8000_0000);   push_r(32'h0, 1'b1, 2, 1'b0);
    req = 4'b1111;
    wait_grant(g, 300);
    c = 0;
    while (!rsp_valid && c < 200) begin
      @(negedge clk);
      c++;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_sum", 64'(rsp_sum), 64'h30);
      chk("bp_id", 64'(rsp_id), 64'(1));
      chk("bp_gnt", 64'(gnt), 64'(0));
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_gnt_gap", 64'(gnt), 64'(0));
    @(negedge clk);
    chk("bp_gnt_next", 64'(gnt), 64'b0100);
    req = '0;
    drain(200);

    // Timeout (ptr = 3)
    hang = 1'b1;
    clr_cnt = 0;
    push_g(3, 32'h1234_5678, 32'h1111_1111);
    push_r(32'h0, 1'b0, 3, 1'b1);
    req = 4'b1000;
    wait_grant(g, 300);
    req = '0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!add_clr && c < 200);
    chk("timeout_cycles", 64'(c), 64'(TIMEOUT));
    drain(200);
    chk("timeout_clr_pulses", 64'(clr_cnt), 64'(1));
    hang = 1'b0;

    // Reset mid-RUN: requester 1 in flight moves ptr to 2, then reset
    push_g(1, 32'h10, 32'h20);
    req = 4'b0010;
    wait_grant(g, 300);
    req = '0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_rsp", 64'(rsp_valid), 64'(0));
    end
    // Fresh request: search from ptr 0 picks 1 over 2
    push_g(1, 32'h10, 32'h20);
    push_r(32'h30, 1'b0, 1, 1'b0);
    run_ops(4'b0110, 1, 1'b1);
    drain(200);

    chk("gq_empty", 64'(gq.size()), 64'(0));
    chk("rq_empty", 64'(rq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_arbiter.md
# serial_add_arbiter

Round-robin arbiter and sequencer that shares one 32-bit serial adder among NREQ requesters. It accepts operand pairs, runs the adder's start/done handshake, and returns sum, carry-out and requester ID through a valid/ready response port. A watchdog clears the adder if it hangs. The block sits between the requesting clients and the serial adder top level, and owns that adder's start and clear inputs.

## Interface
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 32: operand and sum width; must match the adder.
- TIMEOUT, 64: maximum cycles in RUN waiting for add_done, ≥ WIDTH+4.
- IDW, 3: rsp_id width; must satisfy 2^IDW ≥ NREQ.

Ports:
- clk  in  1: single clock, rising edge.
- rst  in  1: reset, synchronous, active-low.
- req  in  NREQ: per-requester request; held until the matching gnt bit is seen.
- a_in  in  NREQ*WIDTH: operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- b_in  in  NREQ*WIDTH: operand B, same packing as a_in.
- gnt  out  NREQ: one-hot, one-cycle pulse; operands of that requester were captured.
- add_a, add_b  out  WIDTH each: registered operands driven to the adder.
- add_start  out  1: adder start; held high for the whole RUN state.
- add_clr  out  1: active-high clear to the adder.
- add_done  in  1: adder done level.
- add_sum  in  WIDTH: adder sum.
- add_cout  in  1: adder carry-out.
- rsp_valid  out  1: response valid.
- rsp_ready  in  1: consumer ready.
- rsp_sum  out  WIDTH: captured sum.
- rsp_cout  out  1: captured carry-out.
- rsp_id  out  IDW: index of the requester that owns the response.
- rsp_err  out  1: operation timed out; rsp_sum = 0 and rsp_cout = 0.

## Operation
- FSM states: IDLE, RUN, DRAIN, RESP. All outputs are registered.
- **IDLE**
  - If req ≠ 0, pick the winner: the first set bit searching upward from ptr, wrapping at NREQ.
  - Capture that requester's operands into add_a/add_b and its index into owner.
  - Set gnt[winner] = 1 for one cycle, set ptr = (winner+1) mod NREQ, clear wdog, and go to RUN.
- **RUN**
  - add_start = 1; wdog increments every cycle.
  - If add_done = 1: capture add_sum/add_cout, set err = 0, go to DRAIN.
  - Else if wdog = TIMEOUT-1: set err = 1, pulse add_clr for one cycle, go to DRAIN.
  - add_done takes priority when it coincides with the timeout.
- **DRAIN**
  - add_start = 0.
  - Wait for add_done = 0 (adder back in its idle state), then go to RESP.
  - After a timeout, add_clr has already forced the adder idle, so DRAIN lasts one cycle.
- **RESP**
  - rsp_valid = 1, with rsp_sum/cout/id/err stable.
  - On rsp_valid && rsp_ready: drop rsp_valid and go to IDLE.
- Arithmetic: the sum is WIDTH bits; overflow appears only in rsp_cout. The arbiter does not modify data.
- Requests arriving outside IDLE are ignored until IDLE; they are not lost as long as req stays high.
- Fairness: a requester that holds req is served within NREQ operations.

## Timing
- Reset values while rst = 0 at a clock edge:
  - state = IDLE, ptr = 0, wdog = 0.
  - gnt = 0, add_start = 0, add_a = add_b = 0.
  - add_clr = 1; it deasserts on the first edge with rst = 1.
  - rsp_valid = 0, rsp_sum = 0, rsp_cout = 0, rsp_id = 0, rsp_err = 0.
- Grant latency: req sampled high in IDLE at edge N gives gnt and add_start high after edge N.
- The adder shows add_done after its LOAD cycle plus WIDTH ADD cycles, nominally WIDTH+2 cycles after add_start rises.
- Response latency: rsp_valid rises 2 cycles after the first add_done-high sample, since the adder needs one cycle to leave DONE once start drops.
- Minimum back-to-back spacing is one IDLE cycle between operations.
- rsp_ready already high when rsp_valid rises: the response completes in one cycle.
- rsp_ready held low: rsp_valid and data hold indefinitely, and no new grant is issued.
- Reset asserted mid-operation (any state): the next edge returns everything to reset values and add_clr = 1. The in-flight operation is dropped with no response.

## Test plan
- **Single request:** req = 0001, A = 0x0000_0005, B = 0x0000_0003 → gnt = 0001 for one cycle; rsp_valid with rsp_sum = 0x8, cout = 0, id = 0, err = 0.
- **Carry-out:** A = 0xFFFF_FFFF, B = 0x0000_0001 on requester 2 → rsp_sum = 0, rsp_cout = 1, rsp_id = 2.
- **Round-robin:** req = 1111 held, with an operation completing each time → grant order 0, 1, 2, 3, 0. Then with ptr = 1 and req = 0101 → requester 2 is granted first.
- **Timeout:** add_done tied low → after TIMEOUT cycles, add_clr pulses once; response has rsp_err = 1, rsp_sum = 0, rsp_cout = 0; the block returns to IDLE.
- **Backpressure:** rsp_ready low for 10 cycles → rsp_valid and data stable throughout, gnt stays 0 despite req = 1111; one cycle after ready rises, the next grant is issued.
- **Reset mid-RUN:** rst low for one edge at RUN cycle 10 → all outputs at reset values, add_clr = 1, no rsp_valid; a fresh request afterwards completes correctly with the grant search starting from ptr = 0.
